// File: rtl/trace_ram_sequencer.sv
// trace_ram_sequencer: turns trace-control command strobes into trace RAM write/read/clear cycles
module trace_ram_sequencer #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int FULL_LEVEL = 8183
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              detect_data_i,
    input  logic [DATA_W-1:0] fp1_data_i,
    input  logic              w_addr_i,
    input  logic              r_addr_i,
    input  logic              write_test_data_i,
    input  logic              read_enable_i,
    input  logic              init_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_re_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W-1:0] wptr_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              busy_o
);
    localparam logic [ADDR_W-1:0] FULL_PTR = ADDR_W'(FULL_LEVEL);

    typedef enum logic [3:0] {
        IDLE, LD_WADDR, LD_RADDR, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, INIT, INIT_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        cmd_q, cmd_p_q, rise;
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d, waddr_q, waddr_d, rptr_inc;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              ovf_q, ovf_d, we_q, we_d;

    assign rise        = cmd_q & ~cmd_p_q;
    assign rptr_inc    = rptr_q + 1'b1;
    assign full_o      = wptr_q >= FULL_PTR;
    assign empty_o     = rptr_q == wptr_q;
    assign wptr_o      = wptr_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = state_q != IDLE;
    assign ram_we_o    = we_q;
    assign ram_waddr_o = waddr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_re_o    = state_q == RD_ISSUE;
    assign ram_raddr_o = rptr_q;
    assign rd_data_o   = rdata_q;
    assign rd_valid_o  = state_q == RD_HOLD;

    // Command levels are registered twice so a rise is seen for exactly one cycle
    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            cmd_q   <= '0;
            cmd_p_q <= '0;
        end else begin
            cmd_q   <= {init_i, read_enable_i, write_test_data_i, r_addr_i, w_addr_i};
            cmd_p_q <= cmd_q;
        end
    end

    // State, pointers and the registered RAM write port
    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Command dispatch (init > w_addr > r_addr > read_enable > write_test_data) and per-state actions
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (enable_i) begin
                if (rise[4]) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (rise[0]) state_d = LD_WADDR;
                else if (rise[1]) state_d = LD_RADDR;
                else if (rise[3]) state_d = empty_o ? IDLE : RD_ISSUE;
                else if (rise[2]) state_d = WRITE;
            end
            LD_WADDR: if (detect_data_i) begin
                wptr_d  = fp1_data_i[ADDR_W-1:0];
                state_d = IDLE;
            end
            LD_RADDR: if (detect_data_i) begin
                rptr_d  = fp1_data_i[ADDR_W-1:0];
                state_d = IDLE;
            end
            WRITE: begin
                if (detect_data_i && full_o) ovf_d = 1'b1;
                if (detect_data_i && !full_o) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = fp1_data_i;
                    wptr_d  = wptr_q + 1'b1;
                end
                if (!write_test_data_i) state_d = IDLE;
            end
            RD_ISSUE: state_d = read_enable_i ? RD_WAIT : IDLE;
            RD_WAIT: begin
                rdata_d = ram_rdata_i;
                state_d = read_enable_i ? RD_HOLD : IDLE;
            end
            RD_HOLD: begin
                if (!read_enable_i) state_d = IDLE;
                else if (rd_ready_i) begin
                    rptr_d  = rptr_inc;
                    state_d = (rptr_inc == wptr_q) ? IDLE : RD_ISSUE;
                end
            end
            INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) state_d = INIT_FIN;
            end
            INIT_FIN: begin
                wptr_d  = '0;
                rptr_d  = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trace_ram_sequencer.sv
// tb_trace_ram_sequencer: randomized and directed checks against a transaction-level model
module tb_trace_ram_sequencer;
    localparam int DEPTH = 8192;
    localparam int FULL  = 8183;

    typedef struct { logic [12:0] a; logic [15:0] d; } acc_t;

    logic        clk_ref = 1'b0;
    logic        rst, enable_i, detect_data_i, rd_ready_i;
    logic [15:0] fp1_data_i;
    logic [4:0]  cmd;
    logic        ram_we_o, ram_re_o, rd_valid_o, full_o, empty_o, overflow_o, busy_o;
    logic [12:0] ram_waddr_o, ram_raddr_o, wptr_o;
    logic [15:0] ram_wdata_o, ram_rdata_i, rd_data_o;

    int          n_vec = 0, n_err = 0, n_re = 0, n_val = 0;
    logic        quiet = 1'b0;
    logic [15:0] m_mem [DEPTH];
    logic [12:0] m_wptr, m_rptr;
    logic        m_ovf;
    acc_t        exp_w[$], exp_r[$];
    logic [15:0] wq[$];
    logic [15:0] ram [DEPTH];

    trace_ram_sequencer dut (
        .clk_ref(clk_ref), .rst(rst), .enable_i(enable_i), .detect_data_i(detect_data_i),
        .fp1_data_i(fp1_data_i), .w_addr_i(cmd[0]), .r_addr_i(cmd[1]),
        .write_test_data_i(cmd[2]), .read_enable_i(cmd[3]), .init_i(cmd[4]),
        .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
        .ram_re_o(ram_re_o), .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .wptr_o(wptr_o), .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
        .busy_o(busy_o)
    );

    always #5 clk_ref = ~clk_ref;

    function automatic logic [15:0] seed(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // RAM with one-cycle read latency
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= seed(i);
        forever begin
            @(posedge clk_ref);
            if (ram_we_o) ram[ram_waddr_o] <= ram_wdata_o;
            if (ram_re_o) ram_rdata_i <= ram[ram_raddr_o];
        end
    end

    // Compare process: RAM traffic and read-back stream against the model queues
    always @(negedge clk_ref) if (rst) begin
        acc_t e;
        if (ram_we_o) begin
            chk("we_expected", 32'(exp_w.size() != 0), 32'd1);
            if (exp_w.size() != 0) begin
                e = exp_w.pop_front();
                chk("we_addr", 32'(ram_waddr_o), 32'(e.a));
                chk("we_data", 32'(ram_wdata_o), 32'(e.d));
            end
        end
        if (ram_re_o) begin
            n_re++;
            chk("re_expected", 32'(exp_r.size() != 0), 32'd1);
            if (exp_r.size() != 0) chk("re_addr", 32'(ram_raddr_o), 32'(exp_r[0].a));
        end
        if (rd_valid_o) n_val++;
        if (rd_valid_o && rd_ready_i) begin
            chk("rd_expected", 32'(exp_r.size() != 0), 32'd1);
            if (exp_r.size() != 0) begin
                e = exp_r.pop_front();
                chk("rd_data", 32'(rd_data_o), 32'(e.d));
            end
        end
        chk("full_rule", 32'(full_o), 32'(wptr_o >= 13'(FULL)));
        if (quiet) begin
            chk("q_wptr", 32'(wptr_o), 32'(m_wptr));
            chk("q_empty", 32'(empty_o), 32'(m_rptr == m_wptr));
            chk("q_ovf", 32'(overflow_o), 32'(m_ovf));
            chk("q_busy", 32'(busy_o), 32'd0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    task automatic load_ptr(input int b, input logic [12:0] v);
        quiet = 1'b0;
        cmd[b] = 1'b1;
        tick(2);
        chk("ld_busy", 32'(busy_o), 32'd1);
        tick($urandom_range(0, 2));
        detect_data_i = 1'b1;
        fp1_data_i = 16'($urandom);
        fp1_data_i[12:0] = v;
        tick(1);
        detect_data_i = 1'b0;
        cmd[b] = 1'b0;
        if (b == 0) m_wptr = v;
        else m_rptr = v;
        tick(1);
        quiet = 1'b1;
    endtask

    task automatic write_words(input int n);
        logic [15:0] w;
        logic        was_full;
        quiet = 1'b0;
        cmd[2] = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 2));
            w = (wq.size() != 0) ? wq.pop_front() : 16'($urandom);
            detect_data_i = 1'b1;
            fp1_data_i = w;
            was_full = m_wptr >= 13'(FULL);
            if (was_full) m_ovf = 1'b1;
            else begin
                exp_w.push_back('{a: m_wptr, d: w});
                m_mem[m_wptr] = w;
                m_wptr = m_wptr + 13'd1;
            end
            tick(1);
            detect_data_i = 1'b0;
            chk("wr_we", 32'(ram_we_o), 32'(!was_full));
            chk("wr_ptr", 32'(wptr_o), 32'(m_wptr));
            chk("wr_ovf", 32'(overflow_o), 32'(m_ovf));
        end
        cmd[2] = 1'b0;
        tick(2);
        quiet = 1'b1;
    endtask

    task automatic read_words(input bit always_ready, output int busy_cyc);
        int          cnt, guard;
        logic [12:0] a;
        quiet = 1'b0;
        cnt = int'(13'(m_wptr - m_rptr));
        for (int i = 0; i < cnt; i++) begin
            a = m_rptr + 13'(i);
            exp_r.push_back('{a: a, d: m_mem[a]});
        end
        cmd[3] = 1'b1;
        tick(2);
        busy_cyc = 0;
        guard = 0;
        while (busy_o && guard < 2000) begin
            busy_cyc++;
            guard++;
            rd_ready_i = always_ready ? 1'b1 : 1'($urandom);
            tick(1);
        end
        chk("rd_finish", 32'(busy_o), 32'd0);
        chk("rd_drained", 32'(exp_r.size()), 32'd0);
        exp_r.delete();
        m_rptr = m_wptr;
        cmd[3] = 1'b0;
        rd_ready_i = 1'b0;
        tick(2);
        quiet = 1'b1;
    endtask

    initial begin
        int bc, re0, val0, k, cnt;
        rst = 1'b0;
        enable_i = 1'b1;
        detect_data_i = 1'b0;
        fp1_data_i = '0;
        cmd = '0;
        rd_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = seed(i);
        m_wptr = '0;
        m_rptr = '0;
        m_ovf = 1'b0;
        tick(3);
        chk("rst_we", 32'(ram_we_o), 0);
        chk("rst_waddr", 32'(ram_waddr_o), 0);
        chk("rst_wdata", 32'(ram_wdata_o), 0);
        chk("rst_re", 32'(ram_re_o), 0);
        chk("rst_raddr", 32'(ram_raddr_o), 0);
        chk("rst_rdata", 32'(rd_data_o), 0);
        chk("rst_valid", 32'(rd_valid_o), 0);
        chk("rst_wptr", 32'(wptr_o), 0);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst = 1'b1;
        tick(2);
        quiet = 1'b1;

        load_ptr(0, 13'h10);
        wq = '{16'hA1A1, 16'hA2A2, 16'hA3A3};
        write_words(3);
        chk("t1_wptr", 32'(wptr_o), 32'h13);
        chk("pin_mem10", 32'(m_mem[16]), 32'hA1A1);

        load_ptr(1, 13'h10);
        re0 = n_re;
        val0 = n_val;
        read_words(1'b1, bc);
        chk("t2_re_pulses", 32'(n_re - re0), 3);
        chk("t2_valid_cycles", 32'(n_val - val0), 3);
        chk("t2_busy_cycles", 32'(bc), 9);
        chk("t2_empty", 32'(empty_o), 1);

        quiet = 1'b0;
        cmd = 5'b00111;
        tick(2);
        detect_data_i = 1'b1;
        fp1_data_i = 16'h0005;
        tick(1);
        detect_data_i = 1'b0;
        cmd = '0;
        m_wptr = 13'd5;
        tick(2);
        quiet = 1'b1;
        chk("prio_wptr", 32'(wptr_o), 5);

        load_ptr(0, 13'd8181);
        wq = '{16'hB1B1, 16'hB2B2, 16'hB3B3, 16'hB4B4};
        write_words(4);
        chk("t3_wptr", 32'(wptr_o), 8183);
        chk("t3_full", 32'(full_o), 1);
        chk("t3_ovf", 32'(overflow_o), 1);
        chk("pin_mem8182", 32'(m_mem[8182]), 32'hB2B2);

        load_ptr(1, 13'd8181);
        quiet = 1'b0;
        exp_r.push_back('{a: 13'd8181, d: m_mem[8181]});
        cmd[3] = 1'b1;
        tick(2);
        chk("t4_issue", 32'(ram_re_o), 1);
        tick(2);
        for (int i = 0; i < 6; i++) begin
            chk("t4_hold_valid", 32'(rd_valid_o), 1);
            chk("t4_hold_data", 32'(rd_data_o), 32'hB1B1);
            tick(1);
        end
        cmd[3] = 1'b0;
        tick(1);
        chk("t4_abort_valid", 32'(rd_valid_o), 0);
        chk("t4_abort_busy", 32'(busy_o), 0);
        exp_r.delete();
        tick(1);
        quiet = 1'b1;
        read_words(1'b0, bc);

        enable_i = 1'b0;
        cmd[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("en_busy", 32'(busy_o), 0);
        end
        cmd[1] = 1'b0;
        tick(2);
        enable_i = 1'b1;

        repeat (60) begin
            case ($urandom_range(0, 3))
                0: load_ptr(0, ($urandom_range(0, 2) == 0) ? 13'($urandom_range(8176, 8186))
                                                          : 13'($urandom_range(0, 8191)));
                1: write_words($urandom_range(0, 6));
                2: begin
                    k = $urandom_range(0, 8);
                    load_ptr(1, 13'(m_wptr - 13'(k)));
                    read_words(1'b0, bc);
                end
                default: begin
                    if (int'(13'(m_wptr - m_rptr)) > 12) load_ptr(1, m_wptr - 13'd2);
                    read_words(1'b0, bc);
                end
            endcase
        end

        quiet = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_w.push_back('{a: 13'(i), d: 16'h0});
            m_mem[i] = 16'h0;
        end
        cmd[4] = 1'b1;
        tick(2);
        cnt = 0;
        while (busy_o && cnt < 9000) begin
            cnt++;
            if (cnt == 2) cmd[4] = 1'b0;
            if (cnt == 100) cmd[0] = 1'b1;
            if (cnt == 200) cmd[0] = 1'b0;
            tick(1);
        end
        chk("init_busy_cycles", 32'(cnt), 8193);
        chk("init_writes_left", 32'(exp_w.size()), 0);
        m_wptr = '0;
        m_rptr = '0;
        m_ovf = 1'b0;
        tick(1);
        quiet = 1'b1;
        chk("init_wptr", 32'(wptr_o), 0);
        chk("init_ovf", 32'(overflow_o), 0);
        chk("init_empty", 32'(empty_o), 1);

        load_ptr(0, 13'd100);
        write_words(3);
        load_ptr(1, 13'd100);
        quiet = 1'b0;
        for (int i = 0; i < 3; i++) exp_r.push_back('{a: 13'(100 + i), d: m_mem[100 + i]});
        cmd[3] = 1'b1;
        tick(4);
        rst = 1'b0;
        #1;
        chk("arst_we", 32'(ram_we_o), 0);
        chk("arst_re", 32'(ram_re_o), 0);
        chk("arst_raddr", 32'(ram_raddr_o), 0);
        chk("arst_rdata", 32'(rd_data_o), 0);
        chk("arst_valid", 32'(rd_valid_o), 0);
        chk("arst_wptr", 32'(wptr_o), 0);
        chk("arst_empty", 32'(empty_o), 1);
        chk("arst_busy", 32'(busy_o), 0);
        exp_r.delete();
        cmd = '0;
        m_wptr = '0;
        m_rptr = '0;
        m_ovf = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        quiet = 1'b1;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
